exc_cp0_unit: RTL and testbench

- Next-generation precise-exception controller plus CP0 for the 5-stage MIPS pipeline.
- Detects faults per stage (F/D/E/M) and carries one exception code per instruction down the pipeline.
- Arbitrates exceptions against NUM_INT masked hardware interrupts at M and updates SR/Cause/EPC.
- Drives pipeline-clear strobes, the handler redirect and the ERET return target.

---
 rtl/exc_pkg.sv | 47 ++++
 rtl/exc_stage_reg.sv | 29 ++
 rtl/exc_cp0_unit.sv | 147 ++++++++++++++
 tb/tb_exc_cp0_unit.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exc_pkg.sv
// Shared definitions for the precise-exception / CP0 block: exception codes,
// CP0 register numbers, bit positions and the per-stage exception record.
package exc_pkg;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    localparam int SR_IE_BIT     = 0;
    localparam int SR_EXL_BIT    = 1;
    localparam int SR_IM_LSB     = 10;
    localparam int CAUSE_EXC_LSB = 2;
    localparam int CAUSE_IP_LSB  = 10;
    localparam int CAUSE_BD_BIT  = 31;

    localparam logic [1:0] MEM_BYTE = 2'd0;
    localparam logic [1:0] MEM_HALF = 2'd1;
    localparam logic [1:0] MEM_WORD = 2'd2;

    typedef struct packed {
        logic       pend;
        logic [4:0] code;
    } exc_t;

    localparam exc_t EXC_NONE = '0;

    // An exception already recorded by an older stage always wins.
    function automatic exc_t exc_merge(input exc_t older, input logic fault,
                                       input logic [4:0] code);
        exc_t r;
        if (older.pend) begin
            r = older;
        end else begin
            r.pend = fault;
            r.code = fault ? code : 5'd0;
        end
        return r;
    endfunction

endpackage

// File: rtl/exc_stage_reg.sv
// One pipeline-boundary exception register: merges this stage's fault into the
// record coming from older stages, with hold (stall), bubble and flush control.
module exc_stage_reg
    import exc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    input  logic       hold,
    input  logic       bubble,
    input  exc_t       older,
    input  logic       fault,
    input  logic [4:0] fault_code,
    output exc_t       q
);

    exc_t merged;

    assign merged = exc_merge(older, fault, fault_code);

    always_ff @(posedge clk) begin
        if (!reset || flush || bubble) begin
            q <= EXC_NONE;
        end else if (!hold) begin
            q <= merged;
        end
    end

endmodule

// File: rtl/exc_cp0_unit.sv
// Precise-exception controller and CP0 (SR/Cause/EPC/PRId) for the 5-stage
// pipeline; exceptions and interrupts are resolved in M.
module exc_cp0_unit
    import exc_pkg::*;
#(
    parameter int          NUM_INT    = 6,
    parameter logic [31:0] PC_LO      = 32'h0000_3000,
    parameter logic [31:0] PC_HI      = 32'h0000_4FFC,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] PRID       = 32'h0000_2017
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic [31:0]        pc_f,
    input  logic               ri_d,
    input  logic               ov_e,
    input  logic               aov_e,
    input  logic               valid_m,
    input  logic [31:0]        pc_m,
    input  logic               bd_m,
    input  logic               mem_rd_m,
    input  logic               mem_wr_m,
    input  logic [1:0]         mem_size_m,
    input  logic [31:0]        addr_m,
    input  logic               mtc0_m,
    input  logic [4:0]         c0_addr_m,
    input  logic [31:0]        c0_wdata_m,
    input  logic               eret_m,
    input  logic [NUM_INT-1:0] hwint,
    output logic               exc_req,
    output logic               clr_fd,
    output logic               clr_de,
    output logic               clr_em,
    output logic               clr_mw,
    output logic [31:0]        redirect_pc,
    output logic [31:0]        c0_rdata,
    output logic [31:0]        epc
);

    exc_t               d_q, e_q, m_q, m_exc;
    logic               f_fault, aov_m, misalign_m, m_fault, int_pend;
    logic [4:0]         exc_code;
    logic [NUM_INT-1:0] ip_q, im_q;
    logic               exl_q, ie_q, bd_q;
    logic [4:0]         exccode_q;
    logic [31:0]        epc_q, epc_base, sr_word, cause_word;
    logic               unused_addr_hi;

    assign unused_addr_hi = ^addr_m[31:2];

    // F -> D
    assign f_fault = (pc_f[1:0] != 2'b00) || (pc_f < PC_LO) || (pc_f > PC_HI);

    exc_stage_reg u_stage_d (
        .clk(clk), .reset(reset), .flush(exc_req), .hold(stall), .bubble(1'b0),
        .older(EXC_NONE), .fault(f_fault), .fault_code(EXC_ADEL), .q(d_q)
    );

    // D -> E
    exc_stage_reg u_stage_e (
        .clk(clk), .reset(reset), .flush(exc_req), .hold(stall), .bubble(1'b0),
        .older(d_q), .fault(ri_d), .fault_code(EXC_RI), .q(e_q)
    );

    // E -> M; the address-overflow flag waits for M to know load vs store
    exc_stage_reg u_stage_m (
        .clk(clk), .reset(reset), .flush(exc_req), .hold(1'b0), .bubble(stall),
        .older(e_q), .fault(ov_e), .fault_code(EXC_OV), .q(m_q)
    );

    always_ff @(posedge clk) begin
        if (!reset || exc_req || stall) begin
            aov_m <= 1'b0;
        end else begin
            aov_m <= aov_e;
        end
    end

    // M: arbitration against interrupts
    assign misalign_m = ((mem_size_m == MEM_HALF) && addr_m[0]) ||
                        ((mem_size_m == MEM_WORD) && (addr_m[1:0] != 2'b00));
    assign m_fault    = (mem_rd_m || mem_wr_m) && (misalign_m || aov_m);
    assign m_exc      = exc_merge(m_q, m_fault, mem_rd_m ? EXC_ADEL : EXC_ADES);

    assign int_pend = ie_q && !exl_q && (|(ip_q & im_q)) && valid_m;
    assign exc_req  = int_pend || (valid_m && m_exc.pend && !exl_q);
    assign exc_code = int_pend ? EXC_INT : m_exc.code;
    assign epc_base = bd_m ? (pc_m - 32'd4) : pc_m;

    assign clr_fd      = exc_req || eret_m;
    assign clr_de      = exc_req || eret_m;
    assign clr_em      = exc_req || eret_m;
    assign clr_mw      = exc_req || eret_m;
    assign redirect_pc = exc_req ? HANDLER_PC : epc_q;
    assign epc         = epc_q;

    // M -> W: CP0 state
    always_ff @(posedge clk) begin
        if (!reset) begin
            ip_q      <= '0;
            im_q      <= '0;
            exl_q     <= 1'b0;
            ie_q      <= 1'b0;
            bd_q      <= 1'b0;
            exccode_q <= 5'd0;
            epc_q     <= 32'd0;
        end else begin
            ip_q <= hwint;
            if (exc_req) begin
                exl_q     <= 1'b1;
                exccode_q <= exc_code;
                bd_q      <= bd_m;
                epc_q     <= {epc_base[31:2], 2'b00};
            end else if (eret_m) begin
                exl_q <= 1'b0;
            end else if (mtc0_m) begin
                if (c0_addr_m == CP0_SR) begin
                    im_q  <= c0_wdata_m[SR_IM_LSB +: NUM_INT];
                    exl_q <= c0_wdata_m[SR_EXL_BIT];
                    ie_q  <= c0_wdata_m[SR_IE_BIT];
                end else if (c0_addr_m == CP0_EPC) begin
                    epc_q <= {c0_wdata_m[31:2], 2'b00};
                end
            end
        end
    end

    always_comb begin
        sr_word                               = '0;
        sr_word[SR_IM_LSB +: NUM_INT]         = im_q;
        sr_word[SR_EXL_BIT]                   = exl_q;
        sr_word[SR_IE_BIT]                    = ie_q;
        cause_word                            = '0;
        cause_word[CAUSE_IP_LSB +: NUM_INT]   = ip_q;
        cause_word[CAUSE_EXC_LSB +: 5]        = exccode_q;
        cause_word[CAUSE_BD_BIT]              = bd_q;
        case (c0_addr_m)
            CP0_SR:    c0_rdata = sr_word;
            CP0_CAUSE: c0_rdata = cause_word;
            CP0_EPC:   c0_rdata = epc_q;
            CP0_PRID:  c0_rdata = PRID;
            default:   c0_rdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_exc_cp0_unit.sv
// Scoreboard bench for exc_cp0_unit: an instruction-level pipeline model
// predicts every cycle's outputs; a negedge monitor pops and compares them.
module tb_exc_cp0_unit;

    localparam logic [31:0] LO  = 32'h0000_3000;
    localparam logic [31:0] HI  = 32'h0000_4FFC;
    localparam logic [31:0] HND = 32'h0000_4180;

    typedef struct packed {
        logic        live;
        logic        vm;
        logic [31:0] pc;
        logic        ri, ov, aov, ld, st, bd, mtc0, eret;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [4:0]  c0a;
        logic [31:0] c0w;
    } ins_t;

    typedef struct packed {
        logic        exc;
        logic        clr;
        logic [31:0] redir;
        logic [31:0] rd;
        logic [31:0] epc;
    } exp_t;

    logic        clk, reset, stall, ri_d, ov_e, aov_e, valid_m, bd_m;
    logic        mem_rd_m, mem_wr_m, mtc0_m, eret_m;
    logic [31:0] pc_f, pc_m, addr_m, c0_wdata_m;
    logic [1:0]  mem_size_m;
    logic [4:0]  c0_addr_m;
    logic [5:0]  hwint;
    logic        exc_req, clr_fd, clr_de, clr_em, clr_mw;
    logic [31:0] redirect_pc, c0_rdata, epc;

    int   checks   = 0;
    int   failures = 0;
    exp_t q[$];

    // reference state: CP0 fields and the instructions occupying D, E, M
    logic [5:0]  r_im, r_ip;
    logic        r_ie, r_exl, r_bd;
    logic [4:0]  r_code;
    logic [31:0] r_epc;
    ins_t        sd, se, sm;
    logic [31:0] npc = 32'h3100;

    exc_cp0_unit dut (
        .clk(clk), .reset(reset), .stall(stall), .pc_f(pc_f), .ri_d(ri_d),
        .ov_e(ov_e), .aov_e(aov_e), .valid_m(valid_m), .pc_m(pc_m), .bd_m(bd_m),
        .mem_rd_m(mem_rd_m), .mem_wr_m(mem_wr_m), .mem_size_m(mem_size_m),
        .addr_m(addr_m), .mtc0_m(mtc0_m), .c0_addr_m(c0_addr_m),
        .c0_wdata_m(c0_wdata_m), .eret_m(eret_m), .hwint(hwint),
        .exc_req(exc_req), .clr_fd(clr_fd), .clr_de(clr_de), .clr_em(clr_em),
        .clr_mw(clr_mw), .redirect_pc(redirect_pc), .c0_rdata(c0_rdata), .epc(epc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ins_t mk_blank();
        ins_t r = '0;
        int   k = $urandom_range(0, 3);
        r.vm   = 1'($urandom_range(0, 1));
        r.pc   = LO + 32'($urandom_range(0, 2047)) * 4;
        r.bd   = ($urandom_range(0, 3) == 0);
        r.ld   = (k == 0);
        r.st   = (k == 1);
        r.size = 2'($urandom_range(0, 2));
        r.addr = $urandom;
        r.c0a  = 5'd12 + 5'($urandom_range(0, 3));
        return r;
    endfunction

    function automatic ins_t nop();
        ins_t r = '0;
        r.live = 1'b1;
        r.vm   = 1'b1;
        r.pc   = npc;
        r.c0a  = 5'd12 + {3'd0, npc[3:2]};
        npc    = npc + 32'd4;
        return r;
    endfunction

    function automatic ins_t rand_ins();
        ins_t r = nop();
        int   k = $urandom_range(0, 3);
        case ($urandom_range(0, 15))
            0: r.pc = LO + 32'($urandom_range(1, 3));
            1: r.pc = LO - 32'd4;
            2: r.pc = HI + 32'd4;
            3: r.pc = HI;
            4: r.pc = LO;
            default: r.pc = LO + 32'($urandom_range(0, 2047)) * 4;
        endcase
        r.ri   = ($urandom_range(0, 7) == 0);
        r.ov   = ($urandom_range(0, 7) == 0);
        r.ld   = (k == 0);
        r.st   = (k == 1);
        r.size = 2'($urandom_range(0, 2));
        r.addr = $urandom;
        r.aov  = (r.ld || r.st) && ($urandom_range(0, 7) == 0);
        r.bd   = ($urandom_range(0, 3) == 0);
        r.mtc0 = !(r.ld || r.st) && ($urandom_range(0, 5) == 0);
        r.eret = !(r.ld || r.st) && !r.mtc0 && ($urandom_range(0, 7) == 0);
        r.c0a  = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'd12 + 5'($urandom_range(0, 3));
        r.c0w  = $urandom;
        return r;
    endfunction

    // Fault of an instruction reaching M: oldest detecting stage wins.
    task automatic m_fault(input ins_t s, output logic p, output logic [4:0] c);
        logic fbad, mis;
        fbad = s.live && ((s.pc[1:0] != 2'b00) || (s.pc < LO) || (s.pc > HI));
        mis  = ((s.size == 2'd1) && s.addr[0]) || ((s.size == 2'd2) && (s.addr[1:0] != 2'b00));
        p = 1'b1;
        if (fbad)                            c = 5'd4;
        else if (s.ri)                       c = 5'd10;
        else if (s.ov)                       c = 5'd12;
        else if ((s.ld || s.st) && (s.aov || mis)) c = s.ld ? 5'd4 : 5'd5;
        else begin p = 1'b0; c = 5'd0; end
    endtask

    task automatic step(input ins_t f, input logic stl, input logic rstn, input logic [5:0] hw);
        logic        fp, intp, exc;
        logic [4:0]  fc;
        logic [31:0] rd, base;
        reset = rstn;  stall = stl;  hwint = hw;  pc_f = f.pc;
        ri_d = sd.ri;  ov_e = se.ov; aov_e = se.aov;
        valid_m = sm.vm; pc_m = sm.pc; bd_m = sm.bd; mem_rd_m = sm.ld; mem_wr_m = sm.st;
        mem_size_m = sm.size; addr_m = sm.addr; mtc0_m = sm.mtc0; c0_addr_m = sm.c0a;
        c0_wdata_m = sm.c0w; eret_m = sm.eret;

        m_fault(sm, fp, fc);
        intp = r_ie && !r_exl && (|(r_ip & r_im)) && sm.vm;
        exc  = intp || (sm.vm && fp && !r_exl);
        case (sm.c0a)
            5'd12:   rd = {16'd0, r_im, 8'd0, r_exl, r_ie};
            5'd13:   rd = {r_bd, 15'd0, r_ip, 3'd0, r_code, 2'd0};
            5'd14:   rd = r_epc;
            5'd15:   rd = 32'h0000_2017;
            default: rd = 32'd0;
        endcase
        q.push_back('{exc: exc, clr: exc || sm.eret, redir: exc ? HND : r_epc, rd: rd, epc: r_epc});

        if (!rstn) begin
            r_im = 0; r_ip = 0; r_ie = 0; r_exl = 0; r_bd = 0; r_code = 0; r_epc = 0;
            sd = mk_blank(); se = mk_blank(); sm = mk_blank();
        end else begin
            if (exc) begin
                base   = sm.bd ? sm.pc - 32'd4 : sm.pc;
                r_exl  = 1'b1;
                r_code = intp ? 5'd0 : fc;
                r_bd   = sm.bd;
                r_epc  = base & ~32'd3;
            end else if (sm.eret) begin
                r_exl = 1'b0;
            end else if (sm.mtc0 && sm.c0a == 5'd12) begin
                r_im = sm.c0w[15:10]; r_exl = sm.c0w[1]; r_ie = sm.c0w[0];
            end else if (sm.mtc0 && sm.c0a == 5'd14) begin
                r_epc = sm.c0w & ~32'd3;
            end
            r_ip = hw;
            if (exc) begin
                sd = mk_blank(); se = mk_blank(); sm = mk_blank();
            end else if (stl) begin
                sm = mk_blank();
            end else begin
                sm = se; se = sd; sd = f;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n, input logic [5:0] hw);
        for (int i = 0; i < n; i++) step(nop(), 1'b0, 1'b1, hw);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                chk("exc_req", {31'd0, exc_req}, {31'd0, e.exc});
                chk("clears", {28'd0, clr_fd, clr_de, clr_em, clr_mw}, {28'd0, {4{e.clr}}});
                chk("redirect_pc", redirect_pc, e.redir);
                chk("c0_rdata", c0_rdata, e.rd);
                chk("epc", epc, e.epc);
            end
        end
    end

    initial begin
        ins_t x;
        reset = 1'b0; stall = 1'b0; pc_f = LO; ri_d = 0; ov_e = 0; aov_e = 0;
        valid_m = 0; pc_m = 0; bd_m = 0; mem_rd_m = 0; mem_wr_m = 0; mem_size_m = 0;
        addr_m = 0; mtc0_m = 0; c0_addr_m = 5'd14; c0_wdata_m = 0; eret_m = 0; hwint = 0;
        r_im = 0; r_ip = 0; r_ie = 0; r_exl = 0; r_bd = 0; r_code = 0; r_epc = 0;
        sd = '0; se = '0; sm = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("rst_exc_req", {31'd0, exc_req}, 32'd0);
        chk("rst_epc", epc, 32'd0);
        chk("rst_redirect", redirect_pc, 32'd0);
        chk("rst_c0_epc", c0_rdata, 32'd0);
        @(posedge clk);
        #1;

        // misaligned fetch
        x = nop(); x.pc = 32'h3002;
        step(x, 0, 1, 0); drain(3, 0);
        chk("t1_epc", epc, 32'h3000);
        x = nop(); x.eret = 1; step(x, 0, 1, 0); drain(3, 0);

        // RI in D beats a later Ov, in a delay slot
        x = nop(); x.pc = 32'h3010; x.ri = 1; x.ov = 1; x.bd = 1;
        step(x, 0, 1, 0); drain(3, 0);
        chk("t2_epc", epc, 32'h300C);
        x = nop(); x.eret = 1; step(x, 0, 1, 0); drain(3, 0);

        // misaligned word store, aligned half load
        x = nop(); x.pc = 32'h3020; x.st = 1; x.size = 2; x.addr = 32'h6;
        step(x, 0, 1, 0); drain(3, 0);
        chk("t4_epc", epc, 32'h3020);
        x = nop(); x.eret = 1; step(x, 0, 1, 0); drain(3, 0);
        x = nop(); x.ld = 1; x.size = 1; x.addr = 32'h1002;
        step(x, 0, 1, 0); drain(3, 0);
        chk("t4_no_exc_epc", epc, 32'h3020);

        // interrupt, masked while EXL, then ERET
        x = nop(); x.mtc0 = 1; x.c0a = 5'd12; x.c0w = 32'h0000_0401;
        step(x, 0, 1, 0); drain(3, 0);
        drain(5, 6'd1);
        x = nop(); x.eret = 1; step(x, 0, 1, 0); drain(4, 0);
        x = nop(); x.mtc0 = 1; x.c0a = 5'd12; x.c0w = 32'h0;
        step(x, 0, 1, 0); drain(3, 0);

        // MTC0 SR suppressed by its own Ov; then MTC0 EPC
        x = nop(); x.pc = 32'h3040; x.ov = 1; x.mtc0 = 1; x.c0a = 5'd12; x.c0w = 32'hFFFF_FFFF;
        step(x, 0, 1, 0); drain(3, 0);
        x = nop(); x.eret = 1; step(x, 0, 1, 0); drain(3, 0);
        x = nop(); x.mtc0 = 1; x.c0a = 5'd14; x.c0w = 32'h3007;
        step(x, 0, 1, 0); drain(3, 0);
        chk("t5_epc", epc, 32'h3004);

        // reset while an M exception is pending
        x = nop(); x.pc = 32'h3050; x.ld = 1; x.size = 2; x.addr = 32'h1;
        step(x, 0, 1, 0); drain(2, 0);
        step(nop(), 0, 0, 0);
        chk("t6_rst_epc", epc, 32'd0);
        drain(2, 0);

        // stall holds an RI code in the D/E registers
        x = nop(); x.pc = 32'h3060; x.ri = 1;
        step(x, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(nop(), 1, 1, 0);
        drain(3, 0);
        chk("t6_stall_epc", epc, 32'h3060);
        x = nop(); x.eret = 1; step(x, 0, 1, 0); drain(3, 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [5:0] hw;
            if (npc > 32'h4F00) npc = 32'h3100;
            hw = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
            step(rand_ins(), ($urandom_range(0, 7) == 0), ($urandom_range(0, 149) != 0), hw);
        end

        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
